// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register. Captures the decoded instruction and its two
// register-file operands under a valid/ready handshake, with hold (stall),
// flush (bubble), writeback bypass at capture, writeback refresh of held
// operands, and a saturating stall-cycle counter for performance debug.
//
// Handshake: a transfer on the decode side happens on a rising edge where
// id_valid & id_ready & ~flush; a transfer on the execute side happens where
// ex_valid & ex_ready. id_valid/ex_valid never depend on the matching ready.
// id_ready is the only combinational path through the block; every ex_*
// output comes straight from a flop.
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            id_rd,
  input  logic [DATA_WIDTH-1:0] id_rd1,
  input  logic [DATA_WIDTH-1:0] id_rd2,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic                  wb_we,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_wd,
  input  logic                  flush,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [DATA_WIDTH-1:0] ex_op1,
  output logic [DATA_WIDTH-1:0] ex_op2,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [4:0]            ex_rd,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
  output logic [15:0]           stall_count
);

  logic                  accept;
  logic                  holding;
  logic [DATA_WIDTH-1:0] cap_op1;
  logic [DATA_WIDTH-1:0] cap_op2;
  logic                  wb_live;
  logic                  refresh_op1;
  logic                  refresh_op2;

  // Ready whenever the slot is empty, being drained, or being squashed.
  assign id_ready = flush | ~ex_valid | ex_ready;
  assign accept   = id_valid & id_ready & ~flush;
  assign holding  = ex_valid & ~ex_ready & ~flush;

  // A write to x0 is architecturally discarded, so it never forwards.
  assign wb_live     = wb_we & (wb_rd != 5'd0);
  assign refresh_op1 = wb_live & (wb_rd == ex_rs1);
  assign refresh_op2 = wb_live & (wb_rd == ex_rs2);

  // Capture bypass: the register file writes on the same edge we sample its
  // combinational read, so a coincident writeback must win over id_rd*.
  always_comb begin
    cap_op1 = id_rd1;
    cap_op2 = id_rd2;
    if (id_rs1 == 5'd0) begin
      cap_op1 = '0;
    end else if (wb_we && (wb_rd == id_rs1)) begin
      cap_op1 = wb_wd;
    end
    if (id_rs2 == 5'd0) begin
      cap_op2 = '0;
    end else if (wb_we && (wb_rd == id_rs2)) begin
      cap_op2 = wb_wd;
    end
  end

  // Slot state and payload: reset > flush > accept > consume > hold/refresh.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_imm   <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      ex_rs1   <= 5'd0;
      ex_rs2   <= 5'd0;
      ex_rd    <= 5'd0;
      ex_ctrl  <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_pc    <= id_pc;
      ex_imm   <= id_imm;
      ex_op1   <= cap_op1;
      ex_op2   <= cap_op2;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_ctrl  <= id_ctrl;
    end else if (ex_valid && ex_ready) begin
      ex_valid <= 1'b0;
    end else if (holding) begin
      if (refresh_op1) begin
        ex_op1 <= wb_wd;
      end
      if (refresh_op2) begin
        ex_op2 <= wb_wd;
      end
    end
  end

  // Count held cycles, sticking at all-ones; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= 16'd0;
    end else if (holding && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
